// File: rtl/multi_channel_timer.sv
// N-channel triggered down-counter timer with one-shot or periodic auto-reload per channel.
// Optional feature: define MULTI_TIMER_ABORT_EN to add the per-channel abort_i port.
module multi_channel_timer #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned COUNTER_BITS = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             clk_en_i,
  input  logic [CHANNELS-1:0]              en_i,
  input  logic [CHANNELS*COUNTER_BITS-1:0] count_i,
  input  logic [CHANNELS-1:0]              trigger_i,
  input  logic [CHANNELS-1:0]              periodic_i,
`ifdef MULTI_TIMER_ABORT_EN
  input  logic [CHANNELS-1:0]              abort_i,
`endif
  output logic [CHANNELS-1:0]              done_o,
  output logic [CHANNELS-1:0]              rdy_o,
  output logic [CHANNELS-1:0]              expired_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [COUNTER_BITS-1:0] CntOne = COUNTER_BITS'(1);

  state_e                  state_q [CHANNELS];
  state_e                  state_d [CHANNELS];
  logic [COUNTER_BITS-1:0] cnt_q   [CHANNELS];
  logic [COUNTER_BITS-1:0] cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]     expired_q, expired_d;
  logic [CHANNELS-1:0]     abort;

`ifdef MULTI_TIMER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = '0;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      expired_d[i] = 1'b0;
      case (state_q[i])
        StIdle, StDone: begin
          if (clk_en_i && trigger_i[i]) begin
            cnt_d[i]   = count_i[i*COUNTER_BITS +: COUNTER_BITS];
            state_d[i] = StRun;
          end
        end
        StRun: begin
          if (clk_en_i && en_i[i]) begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end else begin
              expired_d[i] = 1'b1;
              if (periodic_i[i]) begin
                cnt_d[i] = count_i[i*COUNTER_BITS +: COUNTER_BITS];
              end else begin
                state_d[i] = StDone;
              end
            end
          end
        end
        default: state_d[i] = StIdle;
      endcase
      // Abort wins over trigger and over a same-cycle expiry, suppressing the pulse.
      if (abort[i]) begin
        state_d[i]   = StIdle;
        cnt_d[i]     = '0;
        expired_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      expired_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      expired_q <= expired_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      done_o[i] = (state_q[i] == StDone);
      rdy_o[i]  = (state_q[i] != StRun);
    end
  end

  assign expired_o = expired_q;

endmodule
